// File: rtl/gfx_pkg.sv
// Shared graphics definitions: blitter state encoding and default screen/sprite geometry.
package gfx_pkg;

  localparam int unsigned GFX_SPR_W     = 8;
  localparam int unsigned GFX_SPR_H     = 8;
  localparam int unsigned GFX_SCR_W     = 320;
  localparam int unsigned GFX_SCR_H     = 240;
  localparam int unsigned GFX_PIX_W     = 24;
  localparam int unsigned GFX_IMG_W     = 8;
  localparam logic [23:0] GFX_KEY_COLOR = 24'hFF00FF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ADV   = 3'd4
  } blit_state_e;

endpackage

// File: rtl/sprite_blitter_if.sv
// Sprite ROM read bus and frame-buffer write bus.
//   master: blitter side (drives rom_addr/rom_rd, fb_addr/fb_data/fb_wr)
//   slave : memory side (drives rom_valid/rom_data, fb_ack)
interface sprite_blitter_if #(
  parameter int unsigned SPR_W = gfx_pkg::GFX_SPR_W,
  parameter int unsigned SPR_H = gfx_pkg::GFX_SPR_H,
  parameter int unsigned SCR_W = gfx_pkg::GFX_SCR_W,
  parameter int unsigned SCR_H = gfx_pkg::GFX_SCR_H,
  parameter int unsigned PIX_W = gfx_pkg::GFX_PIX_W,
  parameter int unsigned IMG_W = gfx_pkg::GFX_IMG_W
);
  localparam int unsigned AW = IMG_W + $clog2(SPR_H) + $clog2(SPR_W);
  localparam int unsigned FW = $clog2(SCR_W * SCR_H);

  logic [AW-1:0]    rom_addr;
  logic             rom_rd;
  logic             rom_valid;
  logic [PIX_W-1:0] rom_data;
  logic [FW-1:0]    fb_addr;
  logic [PIX_W-1:0] fb_data;
  logic             fb_wr;
  logic             fb_ack;

  modport master (
    output rom_addr, rom_rd, fb_addr, fb_data, fb_wr,
    input  rom_valid, rom_data, fb_ack
  );

  modport slave (
    input  rom_addr, rom_rd, fb_addr, fb_data, fb_wr,
    output rom_valid, rom_data, fb_ack
  );
endinterface

// File: rtl/blit_addr_gen.sv
// Combinational address unit: screen coordinate of the current sprite pixel,
// clip flag, frame-buffer address and (optionally mirrored) ROM column.
//   x_i/y_i       latched sprite origin
//   col_i/row_i   scan position inside the sprite
//   flip_i        horizontal mirror
//   clip_c        pixel lies off-screen
//   fb_addr_c     sy*SCR_W+sx, truncated to FW bits
//   rom_col_c     column to fetch from the sprite ROM
module blit_addr_gen #(
  parameter int unsigned SPR_W = gfx_pkg::GFX_SPR_W,
  parameter int unsigned SCR_W = gfx_pkg::GFX_SCR_W,
  parameter int unsigned SCR_H = gfx_pkg::GFX_SCR_H,
  parameter int unsigned XW    = 9,
  parameter int unsigned YW    = 8,
  parameter int unsigned CW    = 3,
  parameter int unsigned RW    = 3,
  parameter int unsigned FW    = 17
) (
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  input  logic [CW-1:0] col_i,
  input  logic [RW-1:0] row_i,
  input  logic          flip_i,
  output logic          clip_c,
  output logic [FW-1:0] fb_addr_c,
  output logic [CW-1:0] rom_col_c
);
  // One extra bit so a sprite hanging past the edge never wraps back on-screen.
  logic [XW:0] sx_c;
  logic [YW:0] sy_c;

  assign sx_c      = (XW+1)'(x_i) + (XW+1)'(col_i);
  assign sy_c      = (YW+1)'(y_i) + (YW+1)'(row_i);
  assign clip_c    = (sx_c >= (XW+1)'(SCR_W)) || (sy_c >= (YW+1)'(SCR_H));
  assign fb_addr_c = FW'(32'(sy_c) * SCR_W + 32'(sx_c));
  assign rom_col_c = flip_i ? (CW'(SPR_W - 1) - col_i) : col_i;

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks an SPR_W x SPR_H sprite row-major, fetches each on-screen
// pixel from the sprite ROM and writes it to the frame buffer; off-screen pixels
// are skipped without bus traffic.
//   clk, rst_n         clock, asynchronous active-low reset
//   start              begin a draw (ignored while busy)
//   x_pos/y_pos        sprite top-left corner
//   img_sel, flip_h    sprite image and horizontal mirror
//   busy, done         draw in progress / one-cycle completion pulse
//   bus (master)       ROM read and frame-buffer write handshakes
// Build option: define SPRITE_BLITTER_TRANSPARENCY_EN to skip writes of pixels
// equal to KEY_COLOR.
module sprite_blitter
  import gfx_pkg::*;
#(
  parameter int unsigned      SPR_W     = GFX_SPR_W,
  parameter int unsigned      SPR_H     = GFX_SPR_H,
  parameter int unsigned      SCR_W     = GFX_SCR_W,
  parameter int unsigned      SCR_H     = GFX_SCR_H,
  parameter int unsigned      PIX_W     = GFX_PIX_W,
  parameter int unsigned      IMG_W     = GFX_IMG_W,
  parameter logic [PIX_W-1:0] KEY_COLOR = PIX_W'(GFX_KEY_COLOR)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [$clog2(SCR_W)-1:0]   x_pos,
  input  logic [$clog2(SCR_H)-1:0]   y_pos,
  input  logic [IMG_W-1:0]           img_sel,
  input  logic                       flip_h,
  output logic                       busy,
  output logic                       done,
  sprite_blitter_if.master           bus
);
  localparam int unsigned XW = $clog2(SCR_W);
  localparam int unsigned YW = $clog2(SCR_H);
  localparam int unsigned CW = $clog2(SPR_W);
  localparam int unsigned RW = $clog2(SPR_H);
  localparam int unsigned FW = $clog2(SCR_W * SCR_H);
  localparam int unsigned AW = IMG_W + RW + CW;

  blit_state_e      state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;
  logic [IMG_W-1:0] img_q;
  logic             flip_q;

  logic             busy_q, done_q, rom_rd_q, fb_wr_q;
  logic [AW-1:0]    rom_addr_q;
  logic [FW-1:0]    fb_addr_q;
  logic [PIX_W-1:0] fb_data_q;

  logic             clip_c, last_c, key_hit_c, launch_c;
  logic [FW-1:0]    fb_addr_c;
  logic [CW-1:0]    rom_col_c;

  blit_addr_gen #(
    .SPR_W(SPR_W), .SCR_W(SCR_W), .SCR_H(SCR_H),
    .XW(XW), .YW(YW), .CW(CW), .RW(RW), .FW(FW)
  ) u_addr_gen (
    .x_i      (x_q),
    .y_i      (y_q),
    .col_i    (col_q),
    .row_i    (row_q),
    .flip_i   (flip_q),
    .clip_c   (clip_c),
    .fb_addr_c(fb_addr_c),
    .rom_col_c(rom_col_c)
  );

  assign last_c   = (col_q == CW'(SPR_W - 1)) && (row_q == RW'(SPR_H - 1));
  assign launch_c = (state_q == ST_IDLE) && start;

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  assign key_hit_c = (bus.rom_data == KEY_COLOR);
`else
  assign key_hit_c = 1'b0;
`endif

  // State and scan-position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Next state and scan-position advance.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CHECK;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_CHECK: state_d = clip_c ? ST_ADV : ST_READ;
      ST_READ:  if (bus.rom_valid) state_d = key_hit_c ? ST_ADV : ST_WRITE;
      ST_WRITE: if (bus.fb_ack) state_d = ST_ADV;
      ST_ADV: begin
        col_d   = col_q + CW'(1);
        if (col_q == CW'(SPR_W - 1)) row_d = row_q + RW'(1);
        state_d = last_c ? ST_IDLE : ST_CHECK;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latched draw parameters and registered outputs; strobes follow the next state
  // so rom_rd/fb_wr are high exactly while in READ/WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      img_q      <= '0;
      flip_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rom_rd_q   <= 1'b0;
      fb_wr_q    <= 1'b0;
      rom_addr_q <= '0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
    end else begin
      if (launch_c) begin
        x_q    <= x_pos;
        y_q    <= y_pos;
        img_q  <= img_sel;
        flip_q <= flip_h;
      end
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_q == ST_ADV) && last_c;
      rom_rd_q <= (state_d == ST_READ);
      fb_wr_q  <= (state_d == ST_WRITE);
      if ((state_q == ST_CHECK) && !clip_c) begin
        rom_addr_q <= {img_q, row_q, rom_col_c};
        fb_addr_q  <= fb_addr_c;
      end
      if ((state_q == ST_READ) && bus.rom_valid) fb_data_q <= bus.rom_data;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign bus.rom_rd   = rom_rd_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.fb_wr    = fb_wr_q;
  assign bus.fb_addr  = fb_addr_q;
  assign bus.fb_data  = fb_data_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: ROM/frame-buffer responders with programmable latency,
// a reference pixel-walk model feeding read/write scoreboards, and directed draws.
module tb_sprite_blitter;
  localparam int unsigned AW = 14;
  localparam int unsigned FW = 17;
  localparam logic [23:0] KEY = 24'hFF00FF;
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  localparam bit TRANS = 1'b1;
`else
  localparam bit TRANS = 1'b0;
`endif

  typedef struct packed {
    logic [FW-1:0] addr;
    logic [23:0]   data;
  } wr_t;

  logic       clk, rst_n, start, flip_h, busy, done;
  logic [8:0] x_pos;
  logic [7:0] y_pos;
  logic [7:0] img_sel;

  sprite_blitter_if bus ();

  sprite_blitter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .x_pos  (x_pos),
    .y_pos  (y_pos),
    .img_sel(img_sel),
    .flip_h (flip_h),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_rd_q[$];
  wr_t           exp_wr_q[$];

  int  rom_dly = 0, ack_dly = 0, rd_wait = 0, ack_wait = 0;
  int  rd_cnt = 0, wr_cnt = 0, done_cnt = 0, busy_cyc = 0, first_addr = -1;
  bit  wrote_a2 = 0, key_mode = 0, rd_pend = 0, wr_pend = 0;
  logic [AW-1:0] prev_raddr;
  logic [FW-1:0] prev_faddr;
  logic [23:0]   prev_fdata;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] rom_model(input logic [AW-1:0] a);
    if (key_mode && a[5:3] == 3'd0 && a[2:0] == 3'd2) return KEY;
    return {10'h2A5, a};
  endfunction

  // Reference walk of the sprite: expected ROM reads and frame-buffer writes in order.
  task automatic push_model(input int x, input int y, input int img, input bit flip);
    int sx, sy, rc;
    logic [AW-1:0] ra;
    logic [23:0] d;
    wr_t w;
    exp_rd_q.delete();
    exp_wr_q.delete();
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        sx = x + c;
        sy = y + r;
        if (sx < 320 && sy < 240) begin
          rc = flip ? 7 - c : c;
          ra = {8'(img), 3'(r), 3'(rc)};
          exp_rd_q.push_back(ra);
          d = rom_model(ra);
          if (!(TRANS && d == KEY)) begin
            w.addr = FW'(sy * 320 + sx);
            w.data = d;
            exp_wr_q.push_back(w);
          end
        end
      end
    end
  endtask

  // Responders and monitor: sample on the falling edge, answer for the next rising edge.
  initial begin
    wr_t e;
    bus.rom_valid = 1'b0;
    bus.rom_data  = '0;
    bus.fb_ack    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.rom_valid = 1'b0;
        bus.fb_ack    = 1'b0;
        rd_wait = 0; ack_wait = 0; rd_pend = 0; wr_pend = 0;
      end else begin
        if (done) done_cnt++;
        if (busy) busy_cyc++;
        if (rd_pend) begin
          check_eq("rom_rd_hold", 32'(bus.rom_rd), 1);
          check_eq("rom_addr_hold", 32'(bus.rom_addr), 32'(prev_raddr));
        end
        if (wr_pend) begin
          check_eq("fb_wr_hold", 32'(bus.fb_wr), 1);
          check_eq("fb_addr_hold", 32'(bus.fb_addr), 32'(prev_faddr));
          check_eq("fb_data_hold", 32'(bus.fb_data), 32'(prev_fdata));
        end
        rd_pend = 0;
        wr_pend = 0;

        if (bus.rom_valid) begin
          bus.rom_valid = 1'b0;
          bus.rom_data  = 24'h0BAD00;
        end else if (bus.rom_rd) begin
          if (rd_wait >= rom_dly) begin
            rd_wait = 0;
            rd_cnt++;
            check_eq("rd_expected", 32'(exp_rd_q.size() > 0), 1);
            if (exp_rd_q.size() > 0) check_eq("rom_addr", 32'(bus.rom_addr), 32'(exp_rd_q.pop_front()));
            bus.rom_valid = 1'b1;
            bus.rom_data  = rom_model(bus.rom_addr);
          end else begin
            rd_wait++;
            rd_pend    = 1;
            prev_raddr = bus.rom_addr;
          end
        end

        if (bus.fb_ack) begin
          bus.fb_ack = 1'b0;
        end else if (bus.fb_wr) begin
          if (ack_wait >= ack_dly) begin
            ack_wait = 0;
            if (wr_cnt == 0) first_addr = int'(bus.fb_addr);
            if (bus.fb_addr == FW'(2)) wrote_a2 = 1;
            wr_cnt++;
            check_eq("wr_expected", 32'(exp_wr_q.size() > 0), 1);
            if (exp_wr_q.size() > 0) begin
              e = exp_wr_q.pop_front();
              check_eq("fb_addr", 32'(bus.fb_addr), 32'(e.addr));
              check_eq("fb_data", 32'(bus.fb_data), 32'(e.data));
            end
            bus.fb_ack = 1'b1;
          end else begin
            ack_wait++;
            wr_pend    = 1;
            prev_faddr = bus.fb_addr;
            prev_fdata = bus.fb_data;
          end
        end
      end
    end
  end

  task automatic clear_counts();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; busy_cyc = 0; wrote_a2 = 0; first_addr = -1;
  endtask

  task automatic launch(input int x, input int y, input int img, input bit flip);
    @(negedge clk);
    x_pos = 9'(x); y_pos = 8'(y); img_sel = 8'(img); flip_h = flip; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_draw(input string tag, input int x, input int y, input int img,
                          input bit flip, input bit poke, input int exp_wr,
                          input int exp_rd, input int exp_busy);
    bit ok;
    push_model(x, y, img, flip);
    clear_counts();
    launch(x, y, img, flip);
    check_eq({tag, "_busy_on"}, 32'(busy), 1);
    if (poke) begin
      x_pos = 9'd0; y_pos = 8'd0; img_sel = 8'd0; flip_h = ~flip; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (done) begin ok = 1; break; end
    end
    check_eq({tag, "_finished"}, 32'(ok), 1);
    repeat (3) @(negedge clk);
    check_eq({tag, "_done_pulses"}, done_cnt, 1);
    check_eq({tag, "_writes"}, wr_cnt, exp_wr);
    check_eq({tag, "_reads"}, rd_cnt, exp_rd);
    check_eq({tag, "_rd_left"}, exp_rd_q.size(), 0);
    check_eq({tag, "_wr_left"}, exp_wr_q.size(), 0);
    check_eq({tag, "_busy_off"}, 32'(busy), 0);
    if (exp_busy > 0) check_eq({tag, "_busy_cycles"}, busy_cyc, exp_busy);
  endtask

  task automatic check_all_clear(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_rom_rd"}, 32'(bus.rom_rd), 0);
    check_eq({tag, "_fb_wr"}, 32'(bus.fb_wr), 0);
    check_eq({tag, "_rom_addr"}, 32'(bus.rom_addr), 0);
    check_eq({tag, "_fb_addr"}, 32'(bus.fb_addr), 0);
    check_eq({tag, "_fb_data"}, 32'(bus.fb_data), 0);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; start = 1'b0; flip_h = 1'b0;
    x_pos = '0; y_pos = '0; img_sel = '0;
    repeat (3) @(negedge clk);
    check_all_clear("reset");
    rst_n = 1'b1;

    run_draw("origin", 0, 0, 3, 1'b0, 1'b0, 64, 64, 0);
    run_draw("corner", 316, 236, 1, 1'b0, 1'b0, 16, 16, 0);
    run_draw("flip", 0, 0, 5, 1'b1, 1'b0, 64, 64, 0);

    key_mode = 1;
    run_draw("key", 0, 0, 3, 1'b0, 1'b0, TRANS ? 63 : 64, 64, 0);
    check_eq("key_addr2_written", 32'(wrote_a2), TRANS ? 0 : 1);
    key_mode = 0;

    rom_dly = 3; ack_dly = 5;
    run_draw("slow", 100, 50, 7, 1'b1, 1'b1, 64, 64, 0);
    rom_dly = 0; ack_dly = 0;

    run_draw("clipped", 400, 0, 2, 1'b0, 1'b0, 0, 0, 128);

    // Reset in the middle of a draw, then a fresh draw.
    push_model(0, 0, 3, 1'b0);
    clear_counts();
    launch(0, 0, 3, 1'b0);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (wr_cnt >= 20) begin ok = 1; break; end
    end
    check_eq("midrst_reached", 32'(ok), 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_clear("midrst");
    repeat (3) @(negedge clk);
    exp_rd_q.delete();
    exp_wr_q.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midrst_no_done", done_cnt, 0);
    check_eq("midrst_idle", 32'(busy), 0);
    run_draw("restart", 10, 0, 3, 1'b0, 1'b0, 64, 64, 0);
    check_eq("restart_first_addr", first_addr, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have parameter SPR_W, default 8: sprite width in pixels, power of two, 2..64.
REQ-002 SHALL have parameter SPR_H, default 8: sprite height in pixels, power of two, 2..64.
REQ-003 SHALL have parameter SCR_W, default 320: screen width in pixels.
REQ-004 SHALL have parameter SCR_H, default 240: screen height in pixels.
REQ-005 SHALL have parameter PIX_W, default 24: pixel data width.
REQ-006 SHALL have parameter IMG_W, default 8: image-select width.
REQ-007 SHALL have parameter KEY_COLOR, default 24'hFF00FF: transparent colour, PIX_W bits.
REQ-008 SHALL have ports, clock and reset first:
- clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a draw.
- x_pos  in  XW=$clog2(SCR_W)  sprite left column.
- y_pos  in  YW=$clog2(SCR_H)  sprite top row.
- img_sel  in  IMG_W  sprite image index.
- flip_h  in  1  mirror the sprite horizontally.
- busy  out  1  draw in progress.
- done  out  1  one-cycle pulse when a draw completes.
- rom_addr  out  IMG_W+$clog2(SPR_H)+$clog2(SPR_W)  {img, row, col}.
- rom_rd  out  1  ROM read request.
- rom_valid  in  1  ROM data valid.
- rom_data  in  PIX_W  ROM pixel.
- fb_addr  out  FW=$clog2(SCR_W*SCR_H)  frame-buffer address.
- fb_data  out  PIX_W  pixel to write.
- fb_wr  out  1  frame-buffer write request.
- fb_ack  in  1  write accepted.

Function
REQ-009 SHALL capture x_pos, y_pos, img_sel and flip_h on the clock edge where start=1 in IDLE; start SHALL be ignored when busy=1.
REQ-010 SHALL implement states IDLE, CHECK, READ, WRITE and ADV; transitions: IDLE->CHECK on start; CHECK->READ if the pixel is on-screen, else CHECK->ADV; READ->WRITE on rom_valid; WRITE->ADV on fb_ack; ADV->CHECK if pixels remain, else ADV->IDLE.
REQ-011 SHALL scan pixels row-major, col 0..SPR_W-1 within row 0..SPR_H-1; the ROM column SHALL be SPR_W-1-col when flip_h is latched, else col.
REQ-012 SHALL compute screen coordinates sx=x+col and sy=y+row at full width plus one bit, with no wrap-around.
REQ-013 SHALL treat a pixel as clipped when sx>=SCR_W or sy>=SCR_H; a clipped pixel SHALL generate neither rom_rd nor fb_wr.
REQ-014 SHALL drive fb_addr=sy*SCR_W+sx, truncated to FW bits, and hold fb_addr stable while fb_wr=1.
REQ-015 SHALL hold rom_rd=1 with rom_addr stable throughout READ, and capture rom_data on the cycle rom_valid=1.
REQ-016 SHALL hold fb_wr=1 with fb_data equal to the captured pixel throughout WRITE until fb_ack is sampled high.
REQ-017 SHALL assert busy in every state except IDLE, and pulse done=1 for exactly one cycle on the ADV->IDLE transition.
REQ-018 SHALL, for a sprite that is entirely clipped, complete in SPR_W*SPR_H*2 cycles with no ROM or frame-buffer traffic.
REQ-019 SHALL ignore rom_valid outside READ and fb_ack outside WRITE.

Reset
REQ-020 SHALL, while rst_n=0, enter IDLE and clear busy, done, rom_rd, fb_wr, rom_addr, fb_addr, fb_data, all latched inputs and the row/col counters.
REQ-021 SHALL, when reset is asserted mid-draw, abandon the draw immediately with no done pulse; the next start after release SHALL begin a fresh draw.

Configuration
REQ-022 SHALL, when macro SPRITE_BLITTER_TRANSPARENCY_EN is defined, skip the write for any pixel whose captured data equals KEY_COLOR (READ->ADV with no fb_wr).
REQ-023 SHALL, when SPRITE_BLITTER_TRANSPARENCY_EN is undefined, write every on-screen pixel regardless of colour, and KEY_COLOR SHALL be unused.

Structure
REQ-024 SHALL place the state encoding enum and the default screen and sprite geometry constants in shared package gfx_pkg.
REQ-025 SHALL instantiate one sub-module, blit_addr_gen: a combinational unit producing sx, sy, the clip flag, fb_addr and the ROM column.

Verification
REQ-026 SHALL verify: defaults, x=0, y=0, img=3, zero-latency acks -> 64 writes, fb_addr sequence 0..7, 320..327, ..., 2240..2247, then one done pulse.
REQ-027 SHALL verify: x=316, y=236 -> exactly 16 writes (4x4 corner) and 16 ROM reads; cols 4..7 and rows 4..7 are never read.
REQ-028 SHALL verify: flip_h=1, row 0 -> rom_addr col sequence 7,6,...,0 against fb_addr 0..7.
REQ-029 SHALL verify: with SPRITE_BLITTER_TRANSPARENCY_EN defined and ROM pixel 0xFF00FF at col 2 -> 63 writes with no write to address 2; with the macro undefined -> 64 writes.
REQ-030 SHALL verify: rom_valid delayed 3 cycles and fb_ack delayed 5 cycles -> rom_rd, rom_addr, fb_wr, fb_addr and fb_data held stable throughout each wait.
REQ-031 SHALL verify: reset asserted at pixel 20 -> all outputs clear asynchronously, no done pulse; a following start with x=10 -> first write at address 10.
